demux2_buf: RTL and testbench

DEMUX2_BUF -- requirements
Module: demux2_buf

---
 rtl/demux2_buf.sv | 117 +++++++++++
 tb/tb_demux2_buf.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux2_buf.sv
// 1:2 demultiplexer feeding two independent DEPTH-entry FIFOs, with either
// select-driven or ping-pong routing and per-output delivered-word counters.

module demux2_buf_lane #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [7:0]       count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic             pop;

  assign valid = (occ != '0);
  assign full  = (occ == (AW+1)'(DEPTH));
  assign pop   = valid && ready;
  // Gate the head word so an empty (or resetting) lane presents zero, not stale storage.
  assign data  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        count  <= count + 8'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end
endmodule

module demux2_buf #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             alt_mode,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic             out0_valid,
  output logic             out1_valid,
  input  logic             out0_ready,
  input  logic             out1_ready,
  output logic [7:0]       count0,
  output logic [7:0]       count1,
  output logic             pp_ptr,
  output logic             busy
);
  logic [1:0]            full, vld, rdy, push;
  logic [1:0][WIDTH-1:0] head;
  logic [1:0][7:0]       cnt;
  logic                  dest, accept, pp_q;

  assign dest     = alt_mode ? pp_q : in_sel;
  // Ready looks only at the destination's occupancy; a same-cycle pop never frees a full lane.
  assign in_ready = !full[dest];
  assign accept   = in_valid && in_ready;
  assign rdy      = {out1_ready, out0_ready};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    assign push[g] = accept && (dest == 1'(g));
    demux2_buf_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .wdata (in_data),
      .ready (rdy[g]),
      .full  (full[g]),
      .valid (vld[g]),
      .data  (head[g]),
      .count (cnt[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 pp_q <= 1'b0;
    else if (alt_mode && accept) pp_q <= ~pp_q;
  end

  assign out0_data  = head[0];
  assign out1_data  = head[1];
  assign out0_valid = vld[0];
  assign out1_valid = vld[1];
  assign count0     = cnt[0];
  assign count1     = cnt[1];
  assign pp_ptr     = pp_q;
  assign busy       = vld[0] | vld[1];
endmodule

// File: tb/tb_demux2_buf.sv
// Bench for demux2_buf: directed scenarios plus randomized traffic against a
// queue-based reference model of the two output buffers.

module tb_demux2_buf;
  localparam int W = 34;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_sel, in_valid, in_ready, alt_mode;
  logic [W-1:0] out0_data, out1_data;
  logic         out0_valid, out1_valid, out0_ready, out1_ready;
  logic [7:0]   count0, count1;
  logic         pp_ptr, busy;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int           m_cnt0, m_cnt1;
  bit           m_pp;

  demux2_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .alt_mode(alt_mode),
    .out0_data(out0_data), .out1_data(out1_data),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready),
    .count0(count0), .count1(count1), .pp_ptr(pp_ptr), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic bit m_dest();
    return alt_mode ? m_pp : in_sel;
  endfunction

  function automatic bit m_ready();
    return m_dest() ? (q1.size() < D) : (q0.size() < D);
  endfunction

  function automatic logic [W-1:0] rnd_word();
    return W'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_cnt0 = 0; m_cnt1 = 0; m_pp = 1'b0;
  endtask

  // Advance one clock; the model decides accept/pop from pre-edge state.
  task automatic tick();
    bit acc, p0, p1, dst, live;
    logic [W-1:0] d;
    live = rst_n;
    dst  = m_dest();
    acc  = in_valid && m_ready();
    p0   = (q0.size() > 0) && out0_ready;
    p1   = (q1.size() > 0) && out1_ready;
    d    = in_data;
    @(posedge clk);
    if (live) begin
      if (p0) begin void'(q0.pop_front()); m_cnt0 = (m_cnt0 + 1) % 256; end
      if (p1) begin void'(q1.pop_front()); m_cnt1 = (m_cnt1 + 1) % 256; end
      if (acc) begin
        if (dst) q1.push_back(d); else q0.push_back(d);
        if (alt_mode) m_pp = !m_pp;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = rnd_word();
    alt_mode = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      total++; if ({out0_valid, out1_valid, busy, pp_ptr} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {out0_valid, out1_valid, busy, pp_ptr}); end
      total++; if ({count0, count1} !== 16'h0) begin bad++; $display("FAIL reset_counts got=%h exp=0000", {count0, count1}); end
      total++; if (out0_data !== '0 || out1_data !== '0) begin bad++; $display("FAIL reset_data got=%h/%h exp=0", out0_data, out1_data); end
      tick();
    end
    #2 rst_n = 1'b1; in_valid = 1'b0;
    tick();
    total++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin bad++; $display("FAIL reset_push_ignored got=%b%b exp=00", out0_valid, out1_valid); end
  endtask

  task automatic test_routing();
    out0_ready = 1'b1; out1_ready = 1'b1; alt_mode = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = W'(1);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL route_ready got=%b exp=1", in_ready); end
    total++; if (out0_valid !== 1'b0) begin bad++; $display("FAIL route_no_comb got=%b exp=0", out0_valid); end
    tick();
    in_sel = 1'b1; in_data = W'(2);
    #1;
    total++; if (out0_valid !== 1'b1 || out0_data !== W'(1)) begin bad++; $display("FAIL route_out0 got=%b/%h exp=1/1", out0_valid, out0_data); end
    tick();
    in_valid = 1'b0; in_data = 'x;
    #1;
    total++; if (out1_valid !== 1'b1 || out1_data !== W'(2)) begin bad++; $display("FAIL route_out1 got=%b/%h exp=1/2", out1_valid, out1_data); end
    total++; if (count0 !== 8'd1) begin bad++; $display("FAIL route_count0 got=%0d exp=1", count0); end
    tick();
    total++; if (count1 !== 8'd1 || count1 !== 8'(m_cnt1)) begin bad++; $display("FAIL route_count1 got=%0d exp=1", count1); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = rnd_word();
    out0_ready = 1'b0; out1_ready = 1'b1; alt_mode = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_data = w[i]; #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept%0d got=%b exp=1", i, in_ready); end
      tick();
    end
    in_data = w[2];
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full%0d got=%b exp=0", i, in_ready); end
      tick();
    end
    total++; if (out0_data !== w[0]) begin bad++; $display("FAIL bp_hold got=%h exp=%h", out0_data, w[0]); end
    out0_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_no_bypass got=%b exp=0", in_ready); end
    tick();
    out0_ready = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_rise got=%b exp=1", in_ready); end
    tick();
    total++; if (out0_data !== w[1] || q0.size() != 2) begin bad++; $display("FAIL bp_third got=%h exp=%h", out0_data, w[1]); end
    // out0 full: traffic to out1 must still flow
    in_sel = 1'b1; in_data = rnd_word(); #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL indep_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; in_data = 'x; #1;
    total++; if (out1_valid !== 1'b1 || out1_data !== q1[0]) begin bad++; $display("FAIL indep_out1 got=%b/%h exp=1/%h", out1_valid, out1_data, q1[0]); end
    out0_ready = 1'b1;
    tick();
    total++; if (out0_data !== w[2]) begin bad++; $display("FAIL bp_order got=%h exp=%h", out0_data, w[2]); end
    tick(); tick();
  endtask

  task automatic test_pingpong();
    logic [W-1:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = rnd_word();
    out0_ready = 1'b0; out1_ready = 1'b0; alt_mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = w[i]; in_sel = 1'($urandom()); #1;
      total++; if (pp_ptr !== 1'(i % 2) || in_ready !== 1'b1) begin bad++; $display("FAIL pp_seq%0d got=%b/%b exp=%0d/1", i, pp_ptr, in_ready, i % 2); end
      tick();
    end
    in_valid = 1'b0; in_data = 'x; #1;
    total++; if (pp_ptr !== 1'b0) begin bad++; $display("FAIL pp_final got=%b exp=0", pp_ptr); end
    total++; if (out0_data !== w[0] || out1_data !== w[1]) begin bad++; $display("FAIL pp_head1 got=%h/%h exp=%h/%h", out0_data, out1_data, w[0], w[1]); end
    out0_ready = 1'b1; out1_ready = 1'b1;
    tick();
    total++; if (out0_data !== w[2] || out1_data !== w[3]) begin bad++; $display("FAIL pp_head2 got=%h/%h exp=%h/%h", out0_data, out1_data, w[2], w[3]); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pp_drain got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    out0_ready = 1'b0; out1_ready = 1'b0; in_valid = 1'b1;
    alt_mode = 1'b1; in_data = rnd_word(); tick();
    alt_mode = 1'b0; in_sel = 1'b1; in_data = rnd_word(); tick();
    in_valid = 1'b0; in_data = 'x;
    total++; if (out0_valid !== 1'b1 || out1_valid !== 1'b1 || pp_ptr !== 1'b1) begin bad++; $display("FAIL mid_setup got=%b%b%b exp=111", out0_valid, out1_valid, pp_ptr); end
    #2 rst_n = 1'b0; model_reset();
    #1;
    total++; if ({out0_valid, out1_valid, busy, pp_ptr} !== 4'b0) begin bad++; $display("FAIL mid_flags got=%b exp=0000", {out0_valid, out1_valid, busy, pp_ptr}); end
    total++; if ({count0, count1} !== 16'h0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_counts got=%h/%b exp=0000/1", {count0, count1}, in_ready); end
    tick();
    #2 rst_n = 1'b1;
    tick();
    total++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== '0) begin bad++; $display("FAIL mid_stale got=%b%b/%h exp=00/0", out0_valid, out1_valid, out0_data); end
  endtask

  task automatic test_count_wrap();
    alt_mode = 1'b0; in_sel = 1'b1; out1_ready = 1'b1; out0_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 257; i++) begin
      in_data = rnd_word();
      tick();
    end
    in_valid = 1'b0; in_data = 'x;
    tick();
    total++; if (count1 !== 8'd1 || count0 !== 8'd0) begin bad++; $display("FAIL count_wrap got=%0d/%0d exp=1/0", count1, count0); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom());
      alt_mode   = ($urandom_range(0, 3) == 0);
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      in_data    = in_valid ? rnd_word() : 'x;
      #1;
      total++; if (in_ready !== m_ready()) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, m_ready()); end
      total++; if (out0_valid !== (q0.size() > 0) || out1_valid !== (q1.size() > 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b%b exp=%0d%0d", c, out0_valid, out1_valid, q0.size() > 0, q1.size() > 0); end
      total++; if (out0_data !== (q0.size() > 0 ? q0[0] : '0)) begin bad++; $display("FAIL rnd_data0 c=%0d got=%h exp=%h", c, out0_data, q0.size() > 0 ? q0[0] : '0); end
      total++; if (out1_data !== (q1.size() > 0 ? q1[0] : '0)) begin bad++; $display("FAIL rnd_data1 c=%0d got=%h exp=%h", c, out1_data, q1.size() > 0 ? q1[0] : '0); end
      total++; if (count0 !== 8'(m_cnt0) || count1 !== 8'(m_cnt1)) begin bad++; $display("FAIL rnd_counts c=%0d got=%0d/%0d exp=%0d/%0d", c, count0, count1, m_cnt0, m_cnt1); end
      total++; if (pp_ptr !== m_pp || busy !== (q0.size() + q1.size() > 0)) begin bad++; $display("FAIL rnd_pp_busy c=%0d got=%b/%b exp=%b", c, pp_ptr, busy, m_pp); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_pingpong();
    test_reset_mid();
    test_count_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
